// File: rtl/vga_text_console.sv
// Text-mode console: COLS x ROWS character buffer with cursor, wrap and hardware
// scrolling, plus a 2-clock scan pipeline that turns pixel coordinates into colour.
module vga_text_console #(
  parameter int unsigned COLS    = 70,
  parameter int unsigned ROWS    = 30,
  parameter int unsigned GLYPH_W = 9,
  parameter int unsigned GLYPH_H = 16,
  parameter logic [23:0] FG      = 24'hFFFFFF,
  parameter logic [23:0] BG      = 24'h000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_char,
  input  logic [9:0]  h_addr,
  input  logic [9:0]  v_addr,
  output logic [7:0]  ascii_out,
  output logic [3:0]  row_out,
  output logic [3:0]  col_out,
  input  logic        font_bit,
  output logic [23:0] vga_data,
  output logic [6:0]  cursor_x,
  output logic [4:0]  cursor_y,
  output logic        busy
);

  localparam int unsigned CELLS = COLS * ROWS;
  localparam int unsigned AW    = $clog2(CELLS);

  typedef enum logic [1:0] {S_INIT, S_IDLE, S_CLEAR} state_t;

  // Logical line -> physical line rotation by top, then row-major address.
  function automatic logic [AW-1:0] cell_addr(input logic [4:0] line,
                                              input logic [6:0] col,
                                              input logic [4:0] top);
    logic [5:0] phys;
    phys = {1'b0, line} + {1'b0, top};
    if (phys >= 6'(ROWS)) phys = phys - 6'(ROWS);
    return AW'(phys) * AW'(COLS) + AW'(col);
  endfunction

  state_t         state_q, state_d;
  logic [AW-1:0]  cnt_q, cnt_d;
  logic [6:0]     cx_q, cx_d;
  logic [4:0]     cy_q, cy_d;
  logic [4:0]     top_q, top_d;
  logic           in_ready_q, in_ready_d;
  logic           busy_q, busy_d;

  logic           we;
  logic [AW-1:0]  waddr;
  logic [7:0]     wdata;
  logic           newline;

  logic [7:0]     mem [CELLS];
  logic [7:0]     rd_data_q;
  logic [AW-1:0]  rd_addr;

  logic [9:0]     char_col, char_line;
  logic [3:0]     gx_d, gy_d, gx_q, gy_q;
  logic           blank0_d, blank0_q, blank1_q;
  logic [7:0]     ascii_q;
  logic [3:0]     row_q, col_q;
  logic [23:0]    vga_d, vga_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cx_d    = cx_q;
    cy_d    = cy_q;
    top_d   = top_q;
    we      = 1'b0;
    waddr   = '0;
    wdata   = 8'h20;
    newline = 1'b0;
    unique case (state_q)
      S_INIT: begin
        we    = 1'b1;
        waddr = cnt_q;
        if (cnt_q == AW'(CELLS - 1)) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_CLEAR: begin
        // top has already advanced, so logical line ROWS-1 is the recycled line.
        we    = 1'b1;
        waddr = cell_addr(5'(ROWS - 1), cnt_q[6:0], top_q);
        if (cnt_q == AW'(COLS - 1)) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_IDLE: begin
        if (in_valid && in_ready_q) begin
          if (in_char >= 8'h20 && in_char <= 8'h7E) begin
            we    = 1'b1;
            waddr = cell_addr(cy_q, cx_q, top_q);
            wdata = in_char;
            if (cx_q == 7'(COLS - 1)) newline = 1'b1;
            else                      cx_d = cx_q + 7'd1;
          end else if (in_char == 8'h0A) begin
            newline = 1'b1;
          end else if (in_char == 8'h0D) begin
            cx_d = '0;
          end else if (in_char == 8'h08 && cx_q != '0) begin
            cx_d  = cx_q - 7'd1;
            we    = 1'b1;
            waddr = cell_addr(cy_q, cx_q - 7'd1, top_q);
          end
          if (newline) begin
            cx_d = '0;
            if (cy_q != 5'(ROWS - 1)) begin
              cy_d = cy_q + 5'd1;
            end else begin
              top_d   = (top_q == 5'(ROWS - 1)) ? '0 : top_q + 5'd1;
              cnt_d   = '0;
              state_d = S_CLEAR;
            end
          end
        end
      end
      default: state_d = S_INIT;
    endcase
    in_ready_d = (state_d == S_IDLE);
    busy_d     = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_INIT;
      cnt_q      <= '0;
      cx_q       <= '0;
      cy_q       <= '0;
      top_q      <= '0;
      in_ready_q <= 1'b0;
      busy_q     <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      cx_q       <= cx_d;
      cy_q       <= cy_d;
      top_q      <= top_d;
      in_ready_q <= in_ready_d;
      busy_q     <= busy_d;
    end
  end

  always_comb begin
    char_col  = h_addr / 10'(GLYPH_W);
    gx_d      = 4'(h_addr % 10'(GLYPH_W));
    char_line = v_addr / 10'(GLYPH_H);
    gy_d      = 4'(v_addr % 10'(GLYPH_H));
    blank0_d  = (char_col >= 10'(COLS)) || (char_line >= 10'(ROWS));
    rd_addr   = blank0_d ? '0 : cell_addr(char_line[4:0], char_col[6:0], top_q);
    vga_d     = blank1_q ? BG : (font_bit ? FG : BG);
  end

  // Buffer RAM: unreset so it maps to block RAM; read-during-write yields old data.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rd_data_q <= mem[rd_addr];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gx_q     <= '0;
      gy_q     <= '0;
      blank0_q <= 1'b0;
      blank1_q <= 1'b0;
      ascii_q  <= '0;
      row_q    <= '0;
      col_q    <= '0;
      vga_q    <= '0;
    end else begin
      gx_q     <= gx_d;
      gy_q     <= gy_d;
      blank0_q <= blank0_d;
      blank1_q <= blank0_q;
      ascii_q  <= rd_data_q;
      row_q    <= gy_q;
      col_q    <= gx_q;
      vga_q    <= vga_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign busy      = busy_q;
  assign cursor_x  = cx_q;
  assign cursor_y  = cy_q;
  assign ascii_out = ascii_q;
  assign row_out   = row_q;
  assign col_out   = col_q;
  assign vga_data  = vga_q;

endmodule

// File: doc/vga_text_console.md
Name: vga_text_console

Overview:
- Text-mode front end for the VGA path. It owns a COLS x ROWS character buffer and drives the font ROM lookup ports (ascii/row/col).
- Its console side accepts ASCII characters through a valid/ready stream and handles cursor movement, line wrap and hardware scrolling.
- Its scan side turns pixel coordinates from the VGA timing block into a 24-bit pixel colour, using the 1-bit glyph pixel returned by the font ROM.

Parameters:
- COLS, 70, characters per line
- ROWS, 30, lines on screen
- GLYPH_W, 9, glyph width in pixels
- GLYPH_H, 16, glyph height in pixels (row_out range 0..15)
- FG, 24'hFFFFFF, colour when font_bit=1
- BG, 24'h000000, colour when font_bit=0 or position is blank

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  character offered
- in_ready  out  1  character accepted when in_valid&in_ready at a clk edge
- in_char  in  8  ASCII character
- h_addr  in  10  current pixel x, 0..639
- v_addr  in  10  current pixel y, 0..479
- ascii_out  out  8  glyph code to font ROM
- row_out  out  4  glyph row to font ROM
- col_out  out  4  glyph column (bit index) to font ROM
- font_bit  in  1  combinational ROM pixel for ascii_out/row_out/col_out
- vga_data  out  24  pixel colour
- cursor_x  out  7  cursor column, 0..COLS-1
- cursor_y  out  5  cursor logical line, 0..ROWS-1
- busy  out  1  FSM in INIT or CLEAR

Behaviour:
- Reset values:
  - in_ready=0, busy=1 (FSM=INIT).
  - vga_data=0, ascii_out=0, row_out=0, col_out=0.
  - cursor_x=0, cursor_y=0, top=0.
- Buffer:
  - Dual-port RAM of COLS*ROWS bytes, with one synchronous read port and one write port.
  - A read during a write to the same address returns the old data.
  - The physical line for logical line L is (L+top) mod ROWS; address = phys_line*COLS + col.
- FSM states:
  - INIT: writes 0x20 to every address, 0..COLS*ROWS-1, one per cycle, then goes to IDLE. in_ready=0.
  - IDLE: in_ready=1. Each accepted character is processed in one cycle.
  - CLEAR: writes 0x20 to the COLS cells of the new bottom physical line, one per cycle, then goes to IDLE. in_ready=0.
- Character handling in IDLE:
  - 0x20..0x7E: write at cursor, then cursor_x+1. If cursor_x+1==COLS, perform NEWLINE.
  - 0x0A: NEWLINE.
  - 0x0D: cursor_x=0.
  - 0x08: if cursor_x>0, cursor_x-1 and write 0x20 at the new position. At cursor_x=0 it is a no-op; there is no reverse line wrap.
  - Any other code is accepted and dropped.
- NEWLINE:
  - cursor_x=0.
  - If cursor_y<ROWS-1, then cursor_y+1.
  - Otherwise, top=(top+1) mod ROWS, cursor_y stays ROWS-1, and the FSM goes to CLEAR. No buffer data is copied.
- Scan pipeline, with h/v sampled at edge N:
  - Stage 0 computes char_col=h_addr/GLYPH_W, gx=h_addr%GLYPH_W, char_line=v_addr/GLYPH_H and gy=v_addr%GLYPH_H.
  - blank=(char_col>=COLS)|(char_line>=ROWS).
  - Stage 0 issues the RAM read of logical line char_line.
  - Edge N+1: ascii_out=RAM data, row_out=gy, col_out=gx, and blank is delayed.
  - Edge N+2: vga_data = blank ? BG : (font_bit ? FG : BG).
  - Fixed latency is 2 clocks. The pipeline runs every cycle in all FSM states; during INIT the screen may show stale data.
- top changes take effect on the next read issued. No tearing protection is required.
- Reset asserted mid-INIT or mid-CLEAR aborts the operation, returns all state to reset values and restarts INIT.

Test Plan:
1. Reset, then release -> busy=1 and in_ready=0 for exactly 2100 cycles, then in_ready=1. A scan of any cell then yields ascii_out=0x20.
2. Send 'A'(0x41), then 'B' -> cursor_x=2. Scanning h_addr=9, v_addr=5 gives ascii_out=0x42, row_out=5, col_out=0 one cycle later. With font_bit forced to 1, vga_data=FG two cycles after the sample.
3. Send 70 printable characters -> after the 70th, cursor_x=0 and cursor_y=1. Send 0x08 at cursor_x=0 -> no change. Send 'x', then 0x08 -> cursor_x=0 and cell (1,0) reads 0x20.
4. Fill 30 lines, then send 0x0A on line 29 -> top=1, cursor_y=29, and in_ready=0 for 70 cycles. Logical line 0 then shows the old line 1, and logical line 29 reads all 0x20.
5. Scan h_addr=630 or v_addr in 480..: blank is asserted, so vga_data=BG regardless of font_bit. Also check that h_addr=17 gives col_out=8.
6. Assert rst_n low during CLEAR, then release -> cursor and top are 0, INIT runs a full 2100 cycles, and in_valid held high is not accepted until in_ready=1.
